// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter slice.
// Holds the sequencer state encoding, the MIPS ALU control codes and the
// requester port indices.
package alu_arb_pkg;

  // Sequencer states: waiting for a request, waiting on the ALU, holding a response
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // ALU control encodings (aluControl of the MIPS ALU)
  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;
  localparam logic [2:0] ALU_OP_SLT = 3'b111;

  // Requester port indices
  localparam logic PORT0 = 1'b0;  // execute stage
  localparam logic PORT1 = 1'b1;  // branch/address unit

  // One-hot vector for a port index
  function automatic logic [1:0] port_onehot(input logic idx);
    logic [1:0] v;
    if (idx == PORT1) begin
      v = 2'b10;
    end else begin
      v = 2'b01;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input grant logic for the ALU arbiter.
// Default build: round-robin with a pointer that moves to the other port
// after each completed transaction (pointer starts at port 0).
// With ALU_ARB_FIXED_PRIO_EN defined, port 0 always wins simultaneous
// requests and no pointer state exists.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served_idx,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Clock, reset and completion info are not needed without a pointer
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_update, i_served_idx};

  // Fixed priority: port 0 first, port 1 only when port 0 is not requesting
  always_comb begin
    o_grant     = 2'b00;
    o_grant_idx = PORT0;
    case (i_req)
      2'b01, 2'b11: begin
        o_grant     = 2'b01;
        o_grant_idx = PORT0;
      end
      2'b10: begin
        o_grant     = 2'b10;
        o_grant_idx = PORT1;
      end
      default: begin
        o_grant     = 2'b00;
        o_grant_idx = PORT0;
      end
    endcase
  end

`else

  logic r_ptr;

  // Round-robin pointer: after a served transaction, favour the other port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT0;
    end else if (i_update) begin
      r_ptr <= ~i_served_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Grant selection: a lone requester always wins, a tie goes to the pointer
  always_comb begin
    o_grant     = 2'b00;
    o_grant_idx = PORT0;
    case (i_req)
      2'b01: begin
        o_grant     = 2'b01;
        o_grant_idx = PORT0;
      end
      2'b10: begin
        o_grant     = 2'b10;
        o_grant_idx = PORT1;
      end
      2'b11: begin
        o_grant     = port_onehot(r_ptr);
        o_grant_idx = r_ptr;
      end
      default: begin
        o_grant     = 2'b00;
        o_grant_idx = PORT0;
      end
    endcase
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one MIPS ALU between the execute stage (port 0) and
// the branch/address unit (port 1). One operation in flight at a time:
// accept in IDLE, hold ALU inputs for ALU_LATENCY+1 edges in WAIT, then hold
// the captured result in RESP until the originating port takes it.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins ties).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1    // 0..7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  // Counter reload value; the counter is 3 bits wide to cover latencies 0..7
  localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

  state_t           r_state;
  logic             r_grant_idx;
  logic [2:0]       r_wait_cnt;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_control;

  logic [1:0]       w_grant;
  logic             w_grant_idx;
  logic [1:0]       w_req_ready;
  logic             w_accept;
  logic             w_rsp_hs;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [2:0]       w_sel_op;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req_valid),
    .i_update     (w_rsp_hs),
    .i_served_idx (r_grant_idx),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // Request accept: only in IDLE, one-hot to the granted and still-valid port
  always_comb begin
    w_req_ready = 2'b00;
    if (r_state == ST_IDLE) begin
      w_req_ready = w_grant & req_valid;
    end else begin
      w_req_ready = 2'b00;
    end
  end

  assign w_accept = |w_req_ready;

  // Response handshake: only the granted port's rsp_ready counts
  always_comb begin
    w_rsp_hs = 1'b0;
    if (r_state == ST_RESP) begin
      w_rsp_hs = rsp_ready[r_grant_idx];
    end else begin
      w_rsp_hs = 1'b0;
    end
  end

  // Operand/op selection from the granted port
  always_comb begin
    w_sel_a  = req_a0;
    w_sel_b  = req_b0;
    w_sel_op = req_op0;
    if (w_grant_idx == PORT1) begin
      w_sel_a  = req_a1;
      w_sel_b  = req_b1;
      w_sel_op = req_op1;
    end else begin
      w_sel_a  = req_a0;
      w_sel_b  = req_b0;
      w_sel_op = req_op0;
    end
  end

  // Sequencer FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant_idx   <= PORT0;
      r_wait_cnt    <= 3'd0;
      r_rsp_valid   <= 2'b00;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_control <= 3'b000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a       <= w_sel_a;
            r_alu_b       <= w_sel_b;
            r_alu_control <= w_sel_op;
            r_grant_idx   <= w_grant_idx;
            r_wait_cnt    <= LAT_LOAD;
            r_state       <= ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // ALU inputs stay untouched; capture once the latency has elapsed
          if (r_wait_cnt == 3'd0) begin
            r_rsp_result <= alu_out;
            r_rsp_zero   <= alu_zero;
            r_rsp_valid  <= port_onehot(r_grant_idx);
            r_state      <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 2'b00;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_wait_cnt  <= 3'd0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter with a
// behavioural MIPS ALU model. A main instance (latency 1) carries most of
// the sequences; two extra instances (latency 0 and 3) cover the latency sweep.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int MAIN_LAT = 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] rsp_result, alu_a, alu_b, alu_out;
  logic        rsp_zero, alu_zero;
  logic [2:0]  alu_control;

  // latency-sweep instances share operands, own valid/ready
  logic [1:0]  s_req_valid, s_rsp_ready;
  logic [1:0]  s0_req_ready, s0_rsp_valid, s3_req_ready, s3_rsp_valid;
  logic [31:0] s0_result, s0_alu_a, s0_alu_b, s0_alu_out;
  logic [31:0] s3_result, s3_alu_a, s3_alu_b, s3_alu_out;
  logic        s0_zero, s0_alu_zero, s3_zero, s3_alu_zero;
  logic [2:0]  s0_alu_ctl, s3_alu_ctl;

  int checks = 0;
  int errors = 0;

  // Behavioural ALU: {zero, result}
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    case (op)
      ALU_OP_AND: r = a & b;
      ALU_OP_OR:  r = a | b;
      ALU_OP_ADD: r = a + b;
      ALU_OP_SUB: r = a - b;
      ALU_OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:    r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_out}       = alu_ref(alu_a, alu_b, alu_control);
  assign {s0_alu_zero, s0_alu_out} = alu_ref(s0_alu_a, s0_alu_b, s0_alu_ctl);
  assign {s3_alu_zero, s3_alu_out} = alu_ref(s3_alu_a, s3_alu_b, s3_alu_ctl);

  alu_arbiter #(.WIDTH(32), .ALU_LATENCY(MAIN_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  alu_arbiter #(.WIDTH(32), .ALU_LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s0_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(s0_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_result(s0_result), .rsp_zero(s0_zero), .alu_a(s0_alu_a), .alu_b(s0_alu_b),
    .alu_control(s0_alu_ctl), .alu_out(s0_alu_out), .alu_zero(s0_alu_zero)
  );

  alu_arbiter #(.WIDTH(32), .ALU_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s3_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(s3_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_result(s3_result), .rsp_zero(s3_zero), .alu_a(s3_alu_a), .alu_b(s3_alu_b),
    .alu_control(s3_alu_ctl), .alu_out(s3_alu_out), .alu_zero(s3_alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for rsp_valid[p]; returns edges waited
  task automatic wait_rsp(input int p, input string nm, output int n);
    n = 0;
    while (!rsp_valid[p] && n < 12) begin
      tick();
      n++;
    end
    chk({nm, "_rsp_valid"}, rsp_valid[p], 1'b1);
  endtask

  // Take the pending response on port p and check it clears
  task automatic take_rsp(input int p, input string nm);
    rsp_ready[p] = 1'b1;
    tick();
    rsp_ready[p] = 1'b0;
    #1;
    chk({nm, "_rsp_clear"}, rsp_valid, 2'b00);
  endtask

  // Full single-port transaction with latency and hold checks
  task automatic do_op(input int p, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input string nm);
    int  n;
    logic acc;
    if (p == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end
    req_valid[p] = 1'b1;
    #1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10) begin
      acc = req_ready[p];
      tick();
      n++;
    end
    req_valid[p] = 1'b0;
    chk({nm, "_accept"}, acc, 1'b1);
    wait_rsp(p, nm, n);
    chk({nm, "_latency"}, n, MAIN_LAT + 1);
    chk({nm, "_result"}, rsp_result, er);
    chk({nm, "_zero"}, rsp_zero, ez);
    chk({nm, "_onehot"}, rsp_valid, (p == 0) ? 2'b01 : 2'b10);
    chk({nm, "_alu_ctl"}, alu_control, op);
    chk({nm, "_alu_a"}, alu_a, a);
    take_rsp(p, nm);
  endtask

  typedef struct {
    int          port;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int n, n0, n3;
    logic [1:0] first_oh, second_oh;
    int first_p, second_p;

    vecs[0] = '{0, ALU_OP_ADD, 32'd2,          32'd3,          32'd5,          1'b0};
    vecs[1] = '{1, ALU_OP_SUB, 32'd3,          32'd3,          32'd0,          1'b1};
    vecs[2] = '{0, ALU_OP_AND, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0};
    vecs[3] = '{1, ALU_OP_OR,  32'd4,          32'd1,          32'd5,          1'b0};
    vecs[4] = '{0, ALU_OP_SLT, 32'd1,          32'd2,          32'd1,          1'b0};
    vecs[5] = '{1, ALU_OP_SLT, 32'd5,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[6] = '{0, ALU_OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[7] = '{1, 3'b011,     32'd9,          32'd9,          32'd0,          1'b1};

    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    s_req_valid = 2'b00; s_rsp_ready = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    req_op0 = 3'b000; req_op1 = 3'b000;

    // reset values
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero", rsp_zero, 1'b0);
    chk("rst_alu", {alu_a, alu_b, 29'd0, alu_control}, 64'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // both ports valid from reset; a third p0 request queues behind the winner
    req_a0 = 32'd2; req_b0 = 32'd3; req_op0 = ALU_OP_ADD;
    req_a1 = 32'd4; req_b1 = 32'd1; req_op1 = ALU_OP_OR;
    req_valid = 2'b11;
    #1;
    chk("both_first_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("both_busy_ready", req_ready, 2'b00);
    wait_rsp(0, "both_p0", n);
    chk("both_p0_result", rsp_result, 32'd5);
    chk("both_p1_idle", rsp_valid[1], 1'b0);
    req_a0 = 32'd6; req_b0 = 32'd3; req_op0 = ALU_OP_AND;
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    #1;
    chk("hs_no_overlap_ready", req_ready, 2'b00);
    tick();
    rsp_ready[0] = 1'b0;
    #1;
    first_p   = FIXED ? 0 : 1;
    second_p  = 1 - first_p;
    first_oh  = FIXED ? 2'b01 : 2'b10;
    second_oh = FIXED ? 2'b10 : 2'b01;
    chk("rr_second_ready", req_ready, first_oh);
    tick();
    req_valid[first_p] = 1'b0;
    wait_rsp(first_p, "rr_second", n);
    chk("rr_second_result", rsp_result, (first_p == 0) ? 32'd2 : 32'd5);
    take_rsp(first_p, "rr_second");
    chk("rr_third_ready", req_ready, second_oh);
    tick();
    req_valid[second_p] = 1'b0;
    wait_rsp(second_p, "rr_third", n);
    chk("rr_third_result", rsp_result, (second_p == 0) ? 32'd2 : 32'd5);
    take_rsp(second_p, "rr_third");

    // table of single-port operations
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z,
            $sformatf("vec%0d", i));
    end

    // response back-pressure: SLT 1,2 held 5 cycles, p1 waiting, stray p1 rsp_ready
    req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = ALU_OP_SLT;
    req_valid = 2'b01;
    #1;
    chk("hold_accept_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    req_a1 = 32'd2; req_b1 = 32'd3; req_op1 = ALU_OP_ADD;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    wait_rsp(0, "hold", n);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), rsp_valid, 2'b01);
      chk($sformatf("hold%0d_result", k), rsp_result, 32'd1);
      chk($sformatf("hold%0d_alu", k), {alu_a, alu_b}, {32'd1, 32'd2});
      chk($sformatf("hold%0d_ctl", k), alu_control, ALU_OP_SLT);
      chk($sformatf("hold%0d_ready", k), req_ready, 2'b00);
      tick();
    end
    rsp_ready[1] = 1'b0;
    take_rsp(0, "hold");
    chk("hold_next_ready", req_ready, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, "hold_p1", n);
    chk("hold_p1_result", rsp_result, 32'd5);
    take_rsp(1, "hold_p1");

    // reset during WAIT drops the op
    req_a0 = 32'd9; req_b0 = 32'd9; req_op0 = ALU_OP_ADD;
    req_valid[0] = 1'b1;
    #1;
    chk("rstw_accept_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_rsp_valid", rsp_valid, 2'b00);
    chk("rstw_result", rsp_result, 32'd0);
    chk("rstw_alu", {alu_a, alu_b, 29'd0, alu_control}, 64'd0);
    tick();
    tick();
    chk("rstw_no_rsp", rsp_valid, 2'b00);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rstw_after_no_rsp", rsp_valid, 2'b00);
    do_op(0, ALU_OP_ADD, 32'd7, 32'd1, 32'd8, 1'b0, "rstw_add");

    // latency sweep on the side instances
    req_a0 = 32'd2; req_b0 = 32'd3; req_op0 = ALU_OP_ADD;
    s_req_valid = 2'b01;
    #1;
    chk("lat0_ready", s0_req_ready, 2'b01);
    chk("lat3_ready", s3_req_ready, 2'b01);
    tick();
    s_req_valid = 2'b00;
    n0 = -1;
    n3 = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (n0 < 0 && s0_rsp_valid[0]) n0 = k;
      if (n3 < 0 && s3_rsp_valid[0]) n3 = k;
    end
    chk("lat0_cycles", n0, 1);
    chk("lat3_cycles", n3, 4);
    chk("lat0_result", {s0_zero, s0_result}, {1'b0, 32'd5});
    chk("lat3_result", {s3_zero, s3_result}, {1'b0, 32'd5});
    s_rsp_ready = 2'b01;
    tick();
    s_rsp_ready = 2'b00;
    chk("lat_rsp_clear", {s0_rsp_valid, s3_rsp_valid}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
